pos_dac_tx: RTL and testbench

POS_DAC_TX -- requirements
Module: pos_dac_tx

---
 rtl/pos_dac_tx.sv | 171 +++++++++++++++++
 tb/tb_pos_dac_tx.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_dac_tx.sv
// Serial transmitter for a 24-bit SPI-style position DAC: {command, data} frames,
// single-entry pending buffer (newest sample wins) with a saturating overrun counter.
module pos_dac_tx #(
   parameter int           CLK_DIV       = 2,
   parameter logic [7:0]   DAC_CMD       = 8'h30,
   parameter bit           OFFSET_BINARY = 1'b1
) (
   input  logic        clk_pid,
   input  logic        sys_rst,
   input  logic [15:0] pos_dac,
   input  logic        pos_dac_valid,
   output logic        dac_cs_n,
   output logic        dac_sclk,
   output logic        dac_mosi,
   output logic        dac_ldac_n,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  overrun_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      LDAC,
      GAP
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [4:0] BIT_LAST = 5'd23;

   state_t      state, state_d;
   logic [7:0]  div_cnt, div_cnt_d;
   logic [4:0]  bit_cnt, bit_cnt_d;
   logic        sclk_phase, sclk_phase_d;
   logic [23:0] shreg, shreg_d;
   logic [15:0] pend_val;
   logic        pend_full, pend_full_d;
   logic [15:0] tx_data;
   logic        tick;
   logic        load;
   logic        overrun;

   logic        cs_n_d, sclk_d, mosi_d, ldac_n_d, done_d;

   assign tick    = (div_cnt == DIV_LAST);
   assign tx_data = OFFSET_BINARY ? (pend_val ^ 16'h8000) : pend_val;
   assign busy    = (state != IDLE);

   // NOTE: every output of this block gets a default first, so no path leaves a
   // variable unassigned and no latch is inferred.
   always_comb begin
      state_d      = state;
      div_cnt_d    = tick ? 8'd0 : div_cnt + 8'd1;
      bit_cnt_d    = bit_cnt;
      sclk_phase_d = sclk_phase;
      shreg_d      = shreg;
      load         = 1'b0;

      case (state)
         IDLE: begin
            div_cnt_d    = 8'd0;
            bit_cnt_d    = 5'd0;
            sclk_phase_d = 1'b0;
            if (pend_full) begin
               load    = 1'b1;
               state_d = CS_SETUP;
            end
         end
         CS_SETUP: begin
            if (tick) state_d = SHIFT;
         end
         SHIFT: begin
            if (tick) begin
               if (!sclk_phase) begin
                  sclk_phase_d = 1'b1;
               end else begin
                  // Bit boundary: next bit appears with the following low phase.
                  sclk_phase_d = 1'b0;
                  shreg_d      = {shreg[22:0], 1'b0};
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt_d = 5'd0;
                     state_d   = CS_HOLD;
                  end else begin
                     bit_cnt_d = bit_cnt + 5'd1;
                  end
               end
            end
         end
         CS_HOLD: begin
            if (tick) state_d = LDAC;
         end
         LDAC: begin
            if (tick) state_d = GAP;
         end
         GAP: begin
            // A pending sample chains straight into the next frame with no idle cycle.
            if (tick) begin
               if (pend_full) begin
                  load    = 1'b1;
                  state_d = CS_SETUP;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) shreg_d = {DAC_CMD, tx_data};

      pend_full_d = pos_dac_valid | (pend_full & ~load);
      overrun     = pos_dac_valid & pend_full & ~load;

      cs_n_d   = !(state inside {CS_SETUP, SHIFT, CS_HOLD});
      sclk_d   = (state == SHIFT) && sclk_phase;
      mosi_d   = (state inside {CS_SETUP, SHIFT}) ? shreg[23] : 1'b0;
      ldac_n_d = (state != LDAC);
      done_d   = (state == GAP) && tick;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // updates from pre-edge values regardless of statement order.
   always_ff @(posedge clk_pid or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         div_cnt    <= 8'd0;
         bit_cnt    <= 5'd0;
         sclk_phase <= 1'b0;
         shreg      <= 24'd0;
         pend_val   <= 16'd0;
         pend_full  <= 1'b0;
      end else begin
         state      <= state_d;
         div_cnt    <= div_cnt_d;
         bit_cnt    <= bit_cnt_d;
         sclk_phase <= sclk_phase_d;
         shreg      <= shreg_d;
         pend_full  <= pend_full_d;
         if (pos_dac_valid) pend_val <= pos_dac;
      end
   end

   always_ff @(posedge clk_pid or posedge sys_rst) begin
      if (sys_rst) begin
         overrun_cnt <= 8'd0;
      end else if (overrun && overrun_cnt != 8'hFF) begin
         overrun_cnt <= overrun_cnt + 8'd1;
      end
   end

   // Serial pins are decoded from the current state and registered, giving
   // glitch-free outputs that trail the state register by one cycle.
   always_ff @(posedge clk_pid or posedge sys_rst) begin
      if (sys_rst) begin
         dac_cs_n   <= 1'b1;
         dac_sclk   <= 1'b0;
         dac_mosi   <= 1'b0;
         dac_ldac_n <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         dac_cs_n   <= cs_n_d;
         dac_sclk   <= sclk_d;
         dac_mosi   <= mosi_d;
         dac_ldac_n <= ldac_n_d;
         frame_done <= done_d;
      end
   end

endmodule

// File: tb/tb_pos_dac_tx.sv
// Scoreboard bench for pos_dac_tx: three instances (default, plain binary, CLK_DIV=1)
// observed through a selector by one frame monitor.
module tb_pos_dac_tx;

   logic        clk_pid = 1'b0;
   logic        sys_rst = 1'b1;
   logic [15:0] pos_dac = 16'd0;
   logic        pos_dac_valid = 1'b0;

   logic        cs_n   [3];
   logic        sclk   [3];
   logic        mosi   [3];
   logic        ldac_n [3];
   logic        busy   [3];
   logic        done   [3];
   logic [7:0]  ovr    [3];

   always #5 clk_pid = ~clk_pid;

   pos_dac_tx u_dut0 (
      .clk_pid(clk_pid), .sys_rst(sys_rst), .pos_dac(pos_dac), .pos_dac_valid(pos_dac_valid),
      .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_mosi(mosi[0]), .dac_ldac_n(ldac_n[0]),
      .busy(busy[0]), .frame_done(done[0]), .overrun_cnt(ovr[0]));

   pos_dac_tx #(.OFFSET_BINARY(1'b0)) u_dut1 (
      .clk_pid(clk_pid), .sys_rst(sys_rst), .pos_dac(pos_dac), .pos_dac_valid(pos_dac_valid),
      .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_mosi(mosi[1]), .dac_ldac_n(ldac_n[1]),
      .busy(busy[1]), .frame_done(done[1]), .overrun_cnt(ovr[1]));

   pos_dac_tx #(.CLK_DIV(1)) u_dut2 (
      .clk_pid(clk_pid), .sys_rst(sys_rst), .pos_dac(pos_dac), .pos_dac_valid(pos_dac_valid),
      .dac_cs_n(cs_n[2]), .dac_sclk(sclk[2]), .dac_mosi(mosi[2]), .dac_ldac_n(ldac_n[2]),
      .busy(busy[2]), .frame_done(done[2]), .overrun_cnt(ovr[2]));

   int unsigned sel = 0;
   logic       m_cs_n, m_sclk, m_mosi, m_ldac_n, m_busy, m_done;
   logic [7:0] m_ovr;
   int         m_div;

   assign m_cs_n   = cs_n[sel];
   assign m_sclk   = sclk[sel];
   assign m_mosi   = mosi[sel];
   assign m_ldac_n = ldac_n[sel];
   assign m_busy   = busy[sel];
   assign m_done   = done[sel];
   assign m_ovr    = ovr[sel];
   assign m_div    = (sel == 2) ? 1 : 2;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [23:0] exp_q[$];

   int          done_cnt = 0;
   int          nbits = 0;
   int          frame_cyc = 0;
   int          ldac_cyc = 0;
   int          sclk_hi = 0;
   int          idle_run = 999;
   int          last_gap = 999;
   bit          in_frame = 1'b0;
   bit          prev_sclk = 1'b0;
   bit          prev_mosi = 1'b0;
   logic [23:0] bits = 24'd0;

   task automatic monitor_loop();
      logic [23:0] exp;
      forever begin
         @(negedge clk_pid);
         if (sys_rst) begin
            in_frame  = 1'b0;
            nbits     = 0;
            prev_sclk = 1'b0;
            prev_mosi = 1'b0;
            continue;
         end
         if (!m_cs_n && !in_frame) begin
            in_frame  = 1'b1;
            frame_cyc = 0;
            bits      = 24'd0;
            nbits     = 0;
            ldac_cyc  = 0;
            sclk_hi   = 0;
            last_gap  = idle_run;
         end
         if (in_frame) frame_cyc++;
         else          idle_run++;
         if (in_frame) begin
            if (m_sclk) sclk_hi++;
            if (!prev_sclk && m_sclk && !m_cs_n) begin
               bits = {bits[22:0], m_mosi};
               nbits++;
            end
            if (prev_sclk && m_sclk) begin
               n_cmp++;
               if (m_mosi !== prev_mosi) begin
                  n_fail++;
                  $display("FAIL mosi_stable: mosi=%b while sclk high, required %b", m_mosi, prev_mosi);
               end
            end
            if (!m_ldac_n) ldac_cyc++;
         end
         if (m_done) begin
            done_cnt++;
            n_cmp++;
            if (!in_frame || exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL frame_unexpected: frame_done with in_frame=%b queue=%0d, required an expected frame",
                        in_frame, exp_q.size());
            end else begin
               exp = exp_q.pop_front();
               if (bits !== exp) begin
                  n_fail++;
                  $display("FAIL frame_bits: got %h required %h", bits, exp);
               end
               n_cmp++;
               if (nbits != 24) begin
                  n_fail++;
                  $display("FAIL frame_nbits: got %0d required 24", nbits);
               end
               n_cmp++;
               if (frame_cyc != 52 * m_div) begin
                  n_fail++;
                  $display("FAIL frame_len: got %0d required %0d", frame_cyc, 52 * m_div);
               end
               n_cmp++;
               if (ldac_cyc != m_div) begin
                  n_fail++;
                  $display("FAIL ldac_len: got %0d required %0d", ldac_cyc, m_div);
               end
               n_cmp++;
               if (sclk_hi != 24 * m_div) begin
                  n_fail++;
                  $display("FAIL sclk_high: got %0d required %0d", sclk_hi, 24 * m_div);
               end
            end
            in_frame = 1'b0;
            idle_run = 0;
         end
         prev_sclk = m_sclk;
         prev_mosi = m_mosi;
      end
   endtask

   task automatic send(input logic [15:0] v);
      pos_dac       = v;
      pos_dac_valid = 1'b1;
      @(negedge clk_pid);
      pos_dac_valid = 1'b0;
   endtask

   task automatic do_reset();
      pos_dac_valid = 1'b0;
      sys_rst       = 1'b1;
      repeat (2) @(negedge clk_pid);
      sys_rst       = 1'b0;
      @(negedge clk_pid);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      do begin
         @(negedge clk_pid);
         #1;
         n++;
      end while ((exp_q.size() != 0 || m_busy) && n < budget);
      n_cmp++;
      if (exp_q.size() != 0 || m_busy) begin
         n_fail++;
         $display("FAIL %s_timeout: outstanding=%0d busy=%b, required 0 and 0", name, exp_q.size(), m_busy);
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      sel           = 0;
      sys_rst       = 1'b1;
      pos_dac       = 16'h5555;
      pos_dac_valid = 1'b1;
      repeat (4) @(negedge clk_pid);
      n_cmp++;
      if ({m_cs_n, m_sclk, m_mosi, m_ldac_n, m_busy, m_done} !== 6'b100100) begin
         n_fail++;
         $display("FAIL reset_outputs: cs_n,sclk,mosi,ldac_n,busy,done=%b required 100100",
                  {m_cs_n, m_sclk, m_mosi, m_ldac_n, m_busy, m_done});
      end
      n_cmp++;
      if (m_ovr !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_overrun: got %0d required 0", m_ovr);
      end
      pos_dac_valid = 1'b0;
      @(negedge clk_pid);
      sys_rst = 1'b0;
      repeat (20) @(negedge clk_pid);
      n_cmp++;
      if (m_busy !== 1'b0 || m_cs_n !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_valid_ignored: busy=%b cs_n=%b required 0 1", m_busy, m_cs_n);
      end
   endtask

   task automatic test_basic();
      int d0;
      sel = 0;
      do_reset();
      d0 = done_cnt;
      exp_q.push_back(24'h309234);
      pos_dac       = 16'h1234;
      pos_dac_valid = 1'b1;
      @(negedge clk_pid);
      pos_dac_valid = 1'b0;
      @(negedge clk_pid);
      n_cmp++;
      if (m_cs_n !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_edge1: cs_n=%b required 1", m_cs_n);
      end
      @(negedge clk_pid);
      n_cmp++;
      if (m_cs_n !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_edge2: cs_n=%b required 0", m_cs_n);
      end
      wait_idle(300, "basic");
      n_cmp++;
      if (done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0);
      end
   endtask

   task automatic test_codes();
      sel = 0;
      do_reset();
      exp_q.push_back(24'h307FFF);
      send(16'hFFFF);
      wait_idle(300, "code_neg1");
      exp_q.push_back(24'h300000);
      send(16'h8000);
      wait_idle(300, "code_min");
      sel = 1;
      do_reset();
      exp_q.push_back(24'h301234);
      send(16'h1234);
      wait_idle(300, "code_plain");
   endtask

   task automatic test_overrun();
      int d0;
      sel = 0;
      do_reset();
      d0 = done_cnt;
      exp_q.push_back(24'h308001);
      send(16'h0001);
      repeat (9) @(negedge clk_pid);
      send(16'h0002);
      repeat (9) @(negedge clk_pid);
      exp_q.push_back(24'h308003);
      send(16'h0003);
      wait_idle(400, "overrun");
      n_cmp++;
      if (m_ovr !== 8'd1) begin
         n_fail++;
         $display("FAIL overrun_count: got %0d required 1", m_ovr);
      end
      n_cmp++;
      if (last_gap != 0) begin
         n_fail++;
         $display("FAIL overrun_back_to_back: idle cycles %0d required 0", last_gap);
      end
      n_cmp++;
      if (done_cnt - d0 != 2) begin
         n_fail++;
         $display("FAIL overrun_done_count: got %0d required 2", done_cnt - d0);
      end
   endtask

   task automatic test_mid_reset();
      int n = 0;
      bit stray = 1'b0;
      sel = 0;
      do_reset();
      exp_q.push_back(24'h3080AA);
      send(16'h00AA);
      send(16'h00BB);
      send(16'h00CC);
      n_cmp++;
      if (m_ovr !== 8'd1) begin
         n_fail++;
         $display("FAIL refill_no_overrun: got %0d required 1", m_ovr);
      end
      while (nbits < 10 && n < 400) begin
         @(negedge clk_pid);
         #1;
         n++;
      end
      n_cmp++;
      if (nbits < 10) begin
         n_fail++;
         $display("FAIL midreset_reach_bit10: got %0d bits required 10", nbits);
      end
      sys_rst = 1'b1;
      #1;
      exp_q.delete();
      n_cmp++;
      if ({m_cs_n, m_sclk, m_mosi, m_ldac_n, m_busy, m_done} !== 6'b100100) begin
         n_fail++;
         $display("FAIL midreset_outputs: cs_n,sclk,mosi,ldac_n,busy,done=%b required 100100",
                  {m_cs_n, m_sclk, m_mosi, m_ldac_n, m_busy, m_done});
      end
      n_cmp++;
      if (m_ovr !== 8'd0) begin
         n_fail++;
         $display("FAIL midreset_overrun: got %0d required 0", m_ovr);
      end
      repeat (2) @(negedge clk_pid);
      sys_rst = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk_pid);
         #1;
         if (!m_ldac_n || m_busy) stray = 1'b1;
      end
      n_cmp++;
      if (stray) begin
         n_fail++;
         $display("FAIL midreset_quiet: activity after release=1 required 0");
      end
      exp_q.push_back(24'h30C321);
      send(16'h4321);
      wait_idle(300, "midreset_recover");
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int cyc;
      int d0;
      sel = 2;
      do_reset();
      for (int i = 0; i < 10; i++) exp_q.push_back(24'h308F0F);
      pos_dac       = 16'h0F0F;
      pos_dac_valid = 1'b1;
      while (m_cs_n !== 1'b0 && n < 20) begin
         @(negedge clk_pid);
         #1;
         n++;
      end
      d0  = done_cnt;
      cyc = 1;
      while (done_cnt - d0 < 7 && cyc < 2000) begin
         @(negedge clk_pid);
         #1;
         cyc++;
      end
      n_cmp++;
      if (cyc != 7 * 52) begin
         n_fail++;
         $display("FAIL b2b_seven_frames: got %0d cycles required %0d", cyc, 7 * 52);
      end
      n_cmp++;
      if (m_ovr !== 8'd255) begin
         n_fail++;
         $display("FAIL b2b_overrun_sat: got %0d required 255", m_ovr);
      end
      pos_dac_valid = 1'b0;
      n = 0;
      while (m_busy && n < 300) begin
         @(negedge clk_pid);
         #1;
         n++;
      end
      n_cmp++;
      if (m_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: busy=%b required 0", m_busy);
      end
      exp_q.delete();
   endtask

   initial begin
      fork
         monitor_loop();
      join_none
      test_reset();
      test_basic();
      test_codes();
      test_overrun();
      test_mid_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
